// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA FIFO drain engine.
package dma_pkg;

  // Drain engine control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } drain_state_e;

  // Default FIFO/memory word width and its size in bytes.
  localparam int WORD_WIDTH     = 32;
  localparam int BYTES_PER_WORD = WORD_WIDTH / 8;

  // Byte count of a word of the given bit width.
  function automatic int bytes_per_word(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/drain_skid_buf.sv
// Two-entry output buffer between the FIFO read port and the memory write port.
// head always shows the oldest entry; it is only meaningful when occ != 0.
module drain_skid_buf #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic [1:0]            occ
);

  logic [DATA_WIDTH-1:0] slot0;
  logic [DATA_WIDTH-1:0] slot1;
  logic                  wr_ptr;
  logic                  rd_ptr;

  assign head = rd_ptr ? slot1 : slot0;

  // Storage, pointers and occupancy; a push and a pop together keep occ.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot0  <= '0;
      slot1  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        if (wr_ptr) slot1 <= push_data;
        else        slot0 <= push_data;
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      occ <= occ + 2'(push) - 2'(pop);
    end
  end

  // Overflow and underflow guards.
  always @(posedge clk) begin
    if (!rst) begin
      push_when_full : assert (!(push && occ == 2'd2));
      pop_when_empty : assert (!(pop && occ == 2'd0));
    end
  end

endmodule

// File: rtl/dma_fifo_drain.sv
// Drains len words from a synchronous FIFO (rdata one cycle after rd_en) and
// writes them to consecutive word addresses on a request/grant write port.
// Write handshake: mem_req is a valid; a word transfers in any cycle where
// mem_req and mem_gnt are both high, and while mem_req is high without
// mem_gnt, mem_addr and mem_wdata are held unchanged.
module dma_fifo_drain
  import dma_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  output logic                  done,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  input  logic                  fifo_empty,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_gnt,
  output drain_state_e          dbg_state
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(bytes_per_word(DATA_WIDTH));

  drain_state_e          state;
  logic [LEN_WIDTH-1:0]  rd_left;
  logic [LEN_WIDTH-1:0]  wr_left;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  inflight;
  logic [1:0]            occ;
  logic                  pop;
  logic [2:0]            pending;
  logic [2:0]            room;

  drain_skid_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (fifo_rdata),
    .pop       (pop),
    .head      (mem_wdata),
    .occ       (occ)
  );

  assign mem_req   = (occ != 2'd0);
  assign pop       = mem_req && mem_gnt;
  assign mem_addr  = addr;
  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign dbg_state = state;

  // A read is issued only if its word is guaranteed a buffer slot, counting
  // the word already in flight and a pop happening this cycle.
  assign pending    = {1'b0, occ} + {2'b00, inflight};
  assign room       = 3'd1 + {2'b00, pop};
  assign fifo_rd_en = (state == RUN) && !fifo_empty && (rd_left != '0) && (pending <= room);

  // Control FSM with read/write counters and the write address generator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rd_left  <= '0;
      wr_left  <= '0;
      addr     <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
      case (state)
        IDLE: begin
          if (start) begin
            addr    <= dst_addr;
            rd_left <= len;
            wr_left <= len;
            state   <= (len == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (fifo_rd_en) rd_left <= rd_left - 1'b1;
          if (pop) begin
            wr_left <= wr_left - 1'b1;
            addr    <= addr + ADDR_STEP;
            if (wr_left == LEN_WIDTH'(1)) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
